// File: rtl/cfg_loader_pkg.sv
// cfg_loader shared constants: header field layout, FSM encodings,
// default tile ID width and a payload word-count helper.
package cfg_loader_pkg;

    localparam int CFG_ID_WIDTH      = 8;
    localparam int CFG_HDR_NBITS_LSB = 0;
    localparam int CFG_HDR_NBITS_W   = 16;
    localparam int CFG_HDR_ID_LSB    = 16;

    localparam logic [2:0] CFGL_IDLE  = 3'd0;
    localparam logic [2:0] CFGL_START = 3'd1;
    localparam logic [2:0] CFGL_ID    = 3'd2;
    localparam logic [2:0] CFGL_DATA  = 3'd3;
    localparam logic [2:0] CFGL_DONE  = 3'd4;

    // Payload words following a header: ceil(nbits / w).
    function automatic logic [15:0] cfg_words(
        input logic [15:0] nbits,
        input int unsigned w
    );
        int unsigned t;
        t = (32'(nbits) + w - 1) / w;
        return t[15:0];
    endfunction

endpackage

// File: rtl/cfg_serializer.sv
// cfg_serializer: WORD_W parallel-in/serial-out shifter with a one-entry
// hold register. Ports: load/load_word (accept word into hold), pop
// (take next bit, LSB first), flush (drop buffered data), bit_val (bit
// produced by pop), empty (shifter and hold both empty), hold_empty_nxt
// (hold register state after this edge, lets the FSM register word_ready).
module cfg_serializer #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              crst_n,
    input  logic              flush,
    input  logic              load,
    input  logic [WORD_W-1:0] load_word,
    input  logic              pop,
    output logic              bit_val,
    output logic              empty,
    output logic              hold_empty_nxt
);

    localparam int CW = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] sh, sh_d, hold, hold_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic              hvld, hvld_d;

    assign empty = (cnt == '0) && !hvld;

    always_comb begin
        sh_d    = sh;
        cnt_d   = cnt;
        hold_d  = hold;
        hvld_d  = hvld;
        bit_val = 1'b0;
        if (flush) begin
            cnt_d  = '0;
            hvld_d = 1'b0;
        end else begin
            if (pop && (cnt != '0)) begin
                bit_val = sh[0];
                // Reload on the last bit so a full hold gives no gap.
                if ((cnt == CW'(1)) && hvld) begin
                    sh_d   = hold;
                    cnt_d  = CW'(WORD_W);
                    hvld_d = 1'b0;
                end else begin
                    sh_d  = sh >> 1;
                    cnt_d = cnt - CW'(1);
                end
            end else if ((cnt == '0) && hvld) begin
                // After a stall the first bit comes straight from hold.
                if (pop) begin
                    bit_val = hold[0];
                    sh_d    = hold >> 1;
                    cnt_d   = CW'(WORD_W - 1);
                end else begin
                    sh_d  = hold;
                    cnt_d = CW'(WORD_W);
                end
                hvld_d = 1'b0;
            end
            if (load) begin
                hold_d = load_word;
                hvld_d = 1'b1;
            end
        end
    end

    assign hold_empty_nxt = !hvld_d;

    always_ff @(posedge clk or negedge crst_n) begin
        if (!crst_n) begin
            sh   <= '0;
            cnt  <= '0;
            hold <= '0;
            hvld <= 1'b0;
        end else begin
            sh   <= sh_d;
            cnt  <= cnt_d;
            hold <= hold_d;
            hvld <= hvld_d;
        end
    end

endmodule

// File: rtl/cfg_loader.sv
// cfg_loader: accepts header+payload words over valid/ready and emits
// framed start/ID/payload serial traffic to the configuration chain.
// Ports: word_in/word_valid/word_ready host side; cfg_out_start,
// cfg_bit_out, cfg_bit_out_valid chain side; cfg_bit_in(_valid) chain
// tail; rd_word/rd_valid/rd_ovf readback; busy, cfg_done status.
// Optional readback collector enabled by CFG_LOADER_READBACK_EN.
module cfg_loader
    import cfg_loader_pkg::*;
#(
    parameter int WORD_W   = 32,
    parameter int ID_WIDTH = CFG_ID_WIDTH
) (
    input  logic              clk,
    input  logic              crst_n,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              cfg_out_start,
    output logic              cfg_bit_out,
    output logic              cfg_bit_out_valid,
    input  logic              cfg_bit_in,
    input  logic              cfg_bit_in_valid,
    output logic [WORD_W-1:0] rd_word,
    output logic              rd_valid,
    output logic              rd_ovf,
    output logic              busy,
    output logic              cfg_done
);

    localparam int IW = $clog2(ID_WIDTH + 1);

    logic [2:0]          state, state_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [IW-1:0]       idx, idx_d;
    logic [15:0]         bits_left, bits_d;
    logic [15:0]         words_left, words_d;
    logic                start_d, bit_d, vld_d, done_d, ready_d;
    logic                hs, pop, ser_load, ser_flush;
    logic                ser_bit, ser_empty, hold_empty_nxt;
    logic [15:0]         hdr_nbits;

    assign hs        = word_valid && word_ready;
    assign ser_load  = hs && (state != CFGL_IDLE);
    assign ser_flush = (state == CFGL_IDLE) || (state == CFGL_DONE);
    assign pop       = ((state == CFGL_ID) && (idx == '0)) ||
                       ((state == CFGL_DATA) && (bits_left != '0));
    assign hdr_nbits = word_in[CFG_HDR_NBITS_LSB +: CFG_HDR_NBITS_W];

    cfg_serializer #(.WORD_W(WORD_W)) u_ser (
        .clk            (clk),
        .crst_n         (crst_n),
        .flush          (ser_flush),
        .load           (ser_load),
        .load_word      (word_in),
        .pop            (pop),
        .bit_val        (ser_bit),
        .empty          (ser_empty),
        .hold_empty_nxt (hold_empty_nxt)
    );

    // Next-cycle values; every output below is loaded from these.
    always_comb begin
        state_d = state;
        id_d    = id_q;
        idx_d   = idx;
        bits_d  = bits_left;
        words_d = words_left;
        start_d = 1'b0;
        bit_d   = 1'b0;
        vld_d   = 1'b0;
        done_d  = 1'b0;
        if (ser_load) begin
            words_d = words_left - 16'd1;
        end
        unique case (state)
            CFGL_IDLE: begin
                if (hs) begin
                    id_d    = word_in[CFG_HDR_ID_LSB +: ID_WIDTH];
                    bits_d  = hdr_nbits;
                    words_d = cfg_words(hdr_nbits, WORD_W);
                    if (hdr_nbits == '0) begin
                        state_d = CFGL_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = CFGL_START;
                        start_d = 1'b1;
                    end
                end
            end
            CFGL_START: begin
                state_d = CFGL_ID;
                idx_d   = IW'(ID_WIDTH - 1);
                bit_d   = id_q[ID_WIDTH-1];
                vld_d   = 1'b1;
            end
            CFGL_ID: begin
                if (idx == '0) begin
                    state_d = CFGL_DATA;
                end else begin
                    idx_d = idx - IW'(1);
                    bit_d = id_q[idx - IW'(1)];
                    vld_d = 1'b1;
                end
            end
            CFGL_DATA: begin
                if (bits_left == '0) begin
                    state_d = CFGL_DONE;
                    done_d  = 1'b1;
                end
            end
            CFGL_DONE: begin
                state_d = CFGL_IDLE;
            end
            default: begin
                state_d = CFGL_IDLE;
            end
        endcase
        // Payload bit; an empty serializer leaves valid low (stall).
        if (pop && !ser_empty) begin
            bit_d  = ser_bit;
            vld_d  = 1'b1;
            bits_d = bits_left - 16'd1;
        end
    end

    assign ready_d = (state_d == CFGL_IDLE) ||
                     ((state_d != CFGL_DONE) && hold_empty_nxt &&
                      (words_d != '0));

    always_ff @(posedge clk or negedge crst_n) begin
        if (!crst_n) begin
            state             <= CFGL_IDLE;
            id_q              <= '0;
            idx               <= '0;
            bits_left         <= '0;
            words_left        <= '0;
            word_ready        <= 1'b1;
            cfg_out_start     <= 1'b0;
            cfg_bit_out       <= 1'b0;
            cfg_bit_out_valid <= 1'b0;
            cfg_done          <= 1'b0;
            busy              <= 1'b0;
        end else begin
            state             <= state_d;
            id_q              <= id_d;
            idx               <= idx_d;
            bits_left         <= bits_d;
            words_left        <= words_d;
            word_ready        <= ready_d;
            cfg_out_start     <= start_d;
            cfg_bit_out       <= bit_d;
            cfg_bit_out_valid <= vld_d;
            cfg_done          <= done_d;
            busy              <= (state_d != CFGL_IDLE);
        end
    end

`ifdef CFG_LOADER_READBACK_EN
    localparam int RBW = $clog2(WORD_W);

    logic [WORD_W-2:0] rb_acc;
    logic [RBW-1:0]    rb_cnt;

    always_ff @(posedge clk or negedge crst_n) begin
        if (!crst_n) begin
            rb_acc   <= '0;
            rb_cnt   <= '0;
            rd_word  <= '0;
            rd_valid <= 1'b0;
            rd_ovf   <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (cfg_out_start) begin
                rb_cnt <= '0;
            end else if (cfg_bit_in_valid) begin
                if (rb_cnt == RBW'(WORD_W - 1)) begin
                    rd_word  <= {cfg_bit_in, rb_acc};
                    rd_valid <= 1'b1;
                    rb_cnt   <= '0;
                    if (rd_valid) begin
                        rd_ovf <= 1'b1;
                    end
                end else begin
                    rb_acc[rb_cnt] <= cfg_bit_in;
                    rb_cnt         <= rb_cnt + RBW'(1);
                end
            end
        end
    end
`else
    logic unused_rb;

    assign unused_rb = cfg_bit_in ^ cfg_bit_in_valid;
    assign rd_word   = '0;
    assign rd_valid  = 1'b0;
    assign rd_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_loader.sv
// tb_cfg_loader: directed frames against cfg_loader (WORD_W=32, ID=8),
// with a negedge monitor recording start/bit/done/readback events.
module tb_cfg_loader;

    logic        clk = 1'b0;
    logic        crst_n;
    logic [31:0] word_in;
    logic        word_valid;
    logic        word_ready;
    logic        cfg_out_start;
    logic        cfg_bit_out;
    logic        cfg_bit_out_valid;
    logic        cfg_bit_in;
    logic        cfg_bit_in_valid;
    logic [31:0] rd_word;
    logic        rd_valid;
    logic        rd_ovf;
    logic        busy;
    logic        cfg_done;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int bad    = 0;
    int vcnt   = 0;

    int          start_q[$];
    int          done_q[$];
    int          bcyc_q[$];
    bit          bit_q[$];
    logic [31:0] rd_q[$];

    logic lb_en   = 1'b0;
    logic man_bit = 1'b0;
    logic man_vld = 1'b0;

    assign cfg_bit_in       = lb_en ? cfg_bit_out : man_bit;
    assign cfg_bit_in_valid = lb_en ? (cfg_bit_out_valid && vcnt >= 8)
                                    : man_vld;

    cfg_loader #(.WORD_W(32), .ID_WIDTH(8)) dut (
        .clk               (clk),
        .crst_n            (crst_n),
        .word_in           (word_in),
        .word_valid        (word_valid),
        .word_ready        (word_ready),
        .cfg_out_start     (cfg_out_start),
        .cfg_bit_out       (cfg_bit_out),
        .cfg_bit_out_valid (cfg_bit_out_valid),
        .cfg_bit_in        (cfg_bit_in),
        .cfg_bit_in_valid  (cfg_bit_in_valid),
        .rd_word           (rd_word),
        .rd_valid          (rd_valid),
        .rd_ovf            (rd_ovf),
        .busy              (busy),
        .cfg_done          (cfg_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cfg_out_start) vcnt <= 0;
        else if (cfg_bit_out_valid) vcnt <= vcnt + 1;
    end

    always @(negedge clk) begin
        if (cfg_out_start) start_q.push_back(cyc);
        if (cfg_done) done_q.push_back(cyc);
        if (cfg_bit_out_valid) begin
            bit_q.push_back(cfg_bit_out);
            bcyc_q.push_back(cyc);
        end else if (cfg_bit_out) begin
            bad++;
        end
        if (rd_valid) rd_q.push_back(rd_word);
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        start_q.delete();
        done_q.delete();
        bcyc_q.delete();
        bit_q.delete();
        rd_q.delete();
        bad = 0;
    endtask

    // Called at a negedge; returns at the negedge after the handshake.
    task automatic send_word(input logic [31:0] w, input int gate,
                             output int hs_cyc);
        int n;
        n = 0;
        word_in = w;
        while (n < 300) begin
            word_valid = (cyc >= gate);
            if (word_valid && word_ready) break;
            @(negedge clk);
            n++;
        end
        hs_cyc = cyc;
        chk("handshake", 64'(n < 300), 64'd1);
        @(negedge clk);
        word_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int n = 0; n < 300 && done_q.size() == 0; n++)
            @(negedge clk);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_frame(input logic [31:0] hdr, input logic [31:0] p0,
                             input logic [31:0] p1, input int p1_gate,
                             output int t0);
        int h;
        clear_mon();
        send_word(hdr, 0, t0);
        send_word(p0, 0, h);
        send_word(p1, t0 + p1_gate, h);
        wait_done();
    endtask

    task automatic check_frame(input string tag, input logic [7:0] exp_id,
                               input logic [63:0] exp_pl, input int nb,
                               input int gap, input int t0);
        logic [7:0]  id;
        logic [63:0] pl;
        id = '0;
        pl = '0;
        chk({tag, ".starts"}, 64'(start_q.size()), 64'd1);
        if (start_q.size() > 0)
            chk({tag, ".start_cyc"}, 64'(start_q[0] - t0), 64'd1);
        chk({tag, ".nbits"}, 64'(bit_q.size()), 64'(8 + nb));
        if (bit_q.size() == 8 + nb) begin
            for (int i = 0; i < 8; i++) id = {id[6:0], bit_q[i]};
            for (int i = 0; i < nb; i++) pl[i] = bit_q[8 + i];
            chk({tag, ".id"}, 64'(id), 64'(exp_id));
            chk({tag, ".payload"}, pl, exp_pl);
            chk({tag, ".id_cyc"}, 64'(bcyc_q[0] - t0), 64'd2);
            chk({tag, ".pl_cyc"}, 64'(bcyc_q[8] - t0), 64'd10);
            chk({tag, ".last_cyc"}, 64'(bcyc_q[7 + nb] - t0),
                64'(9 + nb + gap));
        end
        chk({tag, ".dones"}, 64'(done_q.size()), 64'd1);
        if (done_q.size() > 0)
            chk({tag, ".done_cyc"}, 64'(done_q[0] - t0), 64'(10 + nb + gap));
        chk({tag, ".bit_when_invalid"}, 64'(bad), 64'd0);
        chk({tag, ".ready_after"}, 64'(word_ready), 64'd1);
        chk({tag, ".busy_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int t0;
        int h;
        crst_n     = 1'b0;
        word_in    = '0;
        word_valid = 1'b0;
        #22;
        chk("rst.ready", 64'(word_ready), 64'd1);
        chk("rst.outs", 64'({cfg_out_start, cfg_bit_out, cfg_bit_out_valid,
                             rd_valid, rd_ovf, busy, cfg_done}), 64'd0);
        chk("rst.rd_word", 64'(rd_word), 64'd0);
        #1 crst_n = 1'b1;
        @(negedge clk);

        // Gapless frame: ID=7, NBITS=40.
        run_frame(32'h0007_0028, 32'hA5C3_0F96, 32'hFFFF_FFB7, 0, t0);
        check_frame("f40", 8'h07, 64'hB7_A5C3_0F96, 40, 0, t0);

        // Second payload word held back: five stall cycles.
        run_frame(32'h0007_0028, 32'hA5C3_0F96, 32'hFFFF_FFB7, 45, t0);
        check_frame("stall", 8'h07, 64'hB7_A5C3_0F96, 40, 5, t0);

        // NBITS=0: only a done pulse.
        clear_mon();
        send_word(32'h0003_0000, 0, t0);
        chk("z.done", 64'(cfg_done), 64'd1);
        chk("z.busy", 64'(busy), 64'd1);
        chk("z.ready_done", 64'(word_ready), 64'd0);
        @(negedge clk);
        chk("z.ready_idle", 64'(word_ready), 64'd1);
        chk("z.busy_idle", 64'(busy), 64'd0);
        chk("z.starts", 64'(start_q.size()), 64'd0);
        chk("z.bits", 64'(bit_q.size()), 64'd0);
        chk("z.done_cyc", 64'(done_q.size() > 0 ? done_q[0] - t0 : -1),
            64'd1);

        // Reset during payload bit 20 of a 32-bit frame.
        clear_mon();
        send_word(32'h005A_0020, 0, t0);
        send_word(32'hCAFE_F00D, 0, h);
        for (int n = 0; n < 100 && cyc < t0 + 30; n++) @(negedge clk);
        chk("mid.valid", 64'(cfg_bit_out_valid), 64'd1);
        crst_n = 1'b0;
        #1;
        chk("mid.outs", 64'({cfg_out_start, cfg_bit_out, cfg_bit_out_valid,
                             rd_valid, busy, cfg_done}), 64'd0);
        chk("mid.ready", 64'(word_ready), 64'd1);
        #1 crst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("mid.no_done", 64'(done_q.size()), 64'd0);
        chk("mid.idle", 64'({word_ready, busy}), 64'b10);

        // NBITS=33: one bit from the second word, rest discarded.
        run_frame(32'h0012_0021, 32'h1234_5678, 32'hFFFF_FFFF, 0, t0);
        check_frame("f33", 8'h12, 64'h1_1234_5678, 33, 0, t0);

        // 64-bit frame looped back from the chain output.
        lb_en = 1'b1;
        run_frame(32'h003C_0040, 32'hDEAD_BEEF, 32'h0123_4567, 0, t0);
        lb_en = 1'b0;
        check_frame("f64", 8'h3C, 64'h0123_4567_DEAD_BEEF, 64, 0, t0);
`ifdef CFG_LOADER_READBACK_EN
        chk("rb.strobes", 64'(rd_q.size()), 64'd2);
        if (rd_q.size() == 2) begin
            chk("rb.word0", 64'(rd_q[0]), 64'hDEAD_BEEF);
            chk("rb.word1", 64'(rd_q[1]), 64'h0123_4567);
        end
        chk("rb.no_ovf", 64'(rd_ovf), 64'd0);
        // Two completions on consecutive cycles.
        man_bit = 1'b1;
        man_vld = 1'b1;
        force dut.rb_cnt = 5'd31;
        @(negedge clk);
        chk("ovf.first", 64'({rd_valid, rd_ovf}), 64'b10);
        @(negedge clk);
        release dut.rb_cnt;
        man_vld = 1'b0;
        chk("ovf.set", 64'(rd_ovf), 64'd1);
        repeat (3) @(negedge clk);
        chk("ovf.sticky", 64'(rd_ovf), 64'd1);
`else
        chk("rb.strobes", 64'(rd_q.size()), 64'd0);
        man_bit = 1'b1;
        man_vld = 1'b1;
        repeat (40) @(negedge clk);
        man_vld = 1'b0;
        chk("rb.tied", 64'({rd_word, rd_valid, rd_ovf}), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/cfg_loader.md
# cfg_loader

Fabric configuration loader that sits directly upstream of the first tile in each configuration chain. It accepts a word-wide bitstream from the host or SoC side through a valid/ready handshake and serializes it into framed `cfg_out_start` / `cfg_bit_out` / `cfg_bit_out_valid` traffic. Each frame carries a target tile ID followed by that tile's configuration payload. Tiles forward the traffic down the chain, and each tile's `config_block` captures the frame addressed to its ID.

## Interface
Parameters:
- `WORD_W`, 32: host word width. Minimum 16 + `ID_WIDTH`.
- `ID_WIDTH`, `` `ID_WIDTH ``: width of the tile ID field.

Ports:
- `clk`  in  1  single fabric/config clock.
- `crst_n`  in  1  reset, asynchronous assert, active-low.
- `word_in`  in  WORD_W  host bitstream word.
- `word_valid`  in  1  `word_in` valid.
- `word_ready`  out  1  loader accepts `word_in` this cycle.
- `cfg_out_start`  out  1  one-cycle frame-start pulse to the chain.
- `cfg_bit_out`  out  1  serial configuration bit.
- `cfg_bit_out_valid`  out  1  `cfg_bit_out` is valid.
- `cfg_bit_in`  in  1  bit returning from the chain tail.
- `cfg_bit_in_valid`  in  1  returned bit is valid.
- `rd_word`  out  WORD_W  assembled readback word.
- `rd_valid`  out  1  one-cycle strobe for `rd_word`.
- `rd_ovf`  out  1  sticky readback overflow flag.
- `busy`  out  1  a frame is in progress.
- `cfg_done`  out  1  one-cycle pulse at the end of a frame.

## Operation
- Header word fields:
  - `[15:0]` = NBITS, the payload bit count.
  - `[16+ID_WIDTH-1:16]` = target ID.
  - Remaining bits are ignored.
- Payload: ceil(NBITS/WORD_W) words follow the header.
  - Each word is serialized LSB first.
  - Surplus bits in the last word are discarded.
- State machine `IDLE -> START -> ID -> DATA -> DONE -> IDLE`.
  - IDLE: `word_ready`=1. A handshake (`word_valid && word_ready`) latches the header.
    - If NBITS=0, go directly to DONE. No start pulse and no bits are emitted.
    - Otherwise go to START.
  - START: `cfg_out_start`=1 for exactly one cycle, then ID.
  - ID: emits the ID, MSB first, one bit per cycle with valid=1, for ID_WIDTH cycles. Then DATA.
  - DATA: emits one payload bit per cycle from the shifter.
    - If the shifter is empty and the hold register is empty, `cfg_bit_out_valid`=0 (stall). The state and bit count are held until a word arrives.
    - After the NBITS-th bit, go to DONE.
  - DONE: `cfg_done`=1 for one cycle, then IDLE.
- Payload buffering uses a one-entry hold register plus the shifter.
  - Outside IDLE, `word_ready` = hold empty AND (payload words still to accept > 0).
  - Words may be accepted from START onward, so the first payload word can be prefetched during the ID phase.
  - The shifter reloads from hold in the same cycle its last bit is emitted. A continuously valid host therefore produces gapless bits.
- `cfg_bit_out` is 0 whenever valid=0.
- `busy` = (state != IDLE).
- Words presented in DONE are not accepted until IDLE.

## Timing
- Reset value of every output is 0, except `word_ready`, which is 1 (IDLE). Reset is asynchronous: the state returns to IDLE immediately.
- Reset mid-frame: the frame is truncated and no `cfg_done` is issued. Tiles rely on the next `cfg_out_start` to resynchronize.
- Header handshake at cycle 0:
  - start at cycle 1.
  - ID bits at cycles 2..ID_WIDTH+1.
  - payload bits at ID_WIDTH+2 .. ID_WIDTH+1+NBITS, with no stalls.
  - `cfg_done` at ID_WIDTH+2+NBITS.
- A stall adds exactly one cycle per missing-word cycle. It never drops or duplicates a bit.
- All outputs are registered.

## Configuration
- `CFG_LOADER_READBACK_EN` defined:
  - Returned bits (`cfg_bit_in` when `cfg_bit_in_valid`) are collected LSB first into an accumulator.
  - Every WORD_W-th bit produces `rd_word`/`rd_valid` one cycle later.
  - `rd_word` holds its value until the next strobe.
  - If a new word completes while the previous one still shows `rd_valid`, `rd_ovf` is set. It is cleared only by reset.
  - The accumulator count clears on `cfg_out_start`.
- Undefined: `rd_word`, `rd_valid` and `rd_ovf` are tied to 0. `cfg_bit_in` and `cfg_bit_in_valid` are ignored.

## Structure
- `consts.vh` holds:
  - `` `ID_WIDTH ``
  - `` `CFG_HDR_NBITS_LSB ``/`` `CFG_HDR_NBITS_W `` (0/16)
  - `` `CFG_HDR_ID_LSB `` (16)
  - state encodings `` `CFGL_IDLE ``..`` `CFGL_DONE ``
- Sub-module `cfg_serializer`: a WORD_W parallel-in/serial-out shifter with hold register, load handshake, and empty flag. The FSM in `cfg_loader` drives it.

## Test plan
- WORD_W=32, ID_WIDTH=8. Header {ID=7, NBITS=40} plus 2 words, host always valid → start at cycle 1, bits 00000111 at cycles 2–9, 40 payload bits at cycles 10–49 with no gaps, `cfg_done` at 50.
- Same frame, but the second payload word is delayed 5 cycles → valid low for exactly 5 cycles after bit 32, then resume. Total bits = 40 and `cfg_done` at cycle 55.
- Header NBITS=0 → no start pulse, no valid bits, `cfg_done` 1 cycle after the handshake, `word_ready` high again the next cycle.
- `crst_n` pulsed low during DATA bit 20 → all outputs 0 immediately, state IDLE, no `cfg_done`. A new frame afterwards runs correctly.
- NBITS=33 → exactly 33 payload bits. Bits 1–31 of the second word are never emitted.
- Readback enabled, 64 bits looped back from `cfg_bit_out` → two `rd_valid` strobes carrying the payload words, `rd_ovf`=0. Forcing two completions on back-to-back cycles → `rd_ovf`=1.
